i2s_dac_tx: RTL and testbench
=============================

# i2s_dac_tx

Serial transmitter at the output end of the audio path. It accepts 16-bit processed samples from the effects pipeline over a valid/ready handshake and buffers them in a small FIFO. It serializes each sample as a standard I2S frame to the DAC, driving bit clock, word select and data, all derived from the system clock. Mono input: each sample is sent on both the left and right channels.

## Interface
- CLK_DIV, 4: clk cycles per BCLK half-period; legal range 1..255.
- FIFO_DEPTH, 4: sample buffer depth; power of two, at least 2.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_sample  in  16  signed two's-complement sample from the pipeline.
- in_valid  in  1  in_sample is valid this cycle.
- in_ready  out  1  FIFO can accept a sample; registered.
- bclk  out  1  I2S bit clock.
- lrck  out  1  I2S word select; 0 = left, 1 = right.
- sdata  out  1  I2S serial data, MSB first.
- underrun  out  1  sticky flag; an empty FIFO was hit at frame load.

## Operation
- Reset (rst_n=0, asynchronous): bclk=0, lrck=0, sdata=0, underrun=0, in_ready=0. Divider, slot counter, shift register and FIFO pointers are all cleared.
- in_ready is 1 from the first clk edge after reset release while the FIFO is not full. in_ready=0 in any cycle where the FIFO held FIFO_DEPTH entries at the previous edge.
- Push: in_valid && in_ready writes in_sample into the FIFO. When in_ready=0, in_valid is ignored; no data is lost from already-accepted samples.
- Divider div_cnt runs 0..CLK_DIV-1 and wraps. When div_cnt==CLK_DIV-1, bclk toggles.
- A toggle 1->0 is a falling event. The slot counter slot (0..31) increments on each falling event and wraps 31->0.
- lrck = 1 for slot 16..31, else 0.
- Frame word F = {S, S} (32 bits), where S is the sample loaded for this frame.
- On the falling event entering slot 1 (load event):
  - Pop the FIFO into S.
  - If the FIFO is empty, load S=16'h0000 and set underrun=1. underrun is cleared only by reset.
- sdata:
  - Slot s in 1..31: sdata = F[32-s].
  - Slot 0: sdata = F[0] of the previous frame (the previous right-channel LSB). This gives the standard one-BCLK MSB delay after each lrck edge.
  - Slot 0 of the first frame after reset: sdata = 0.
- Simultaneous push and pop with the FIFO empty: the pop sees empty, so zero is loaded and underrun is set. The push still succeeds, and that sample goes to the next frame.
- Simultaneous push and pop with the FIFO non-empty and not full: both occur, and the occupancy is unchanged.
- Samples leave in FIFO (arrival) order; nothing is skipped or duplicated.

## Timing
- bclk period = 2*CLK_DIV clk cycles. Frame = 32 BCLK periods = 64*CLK_DIV clk cycles. Sample rate = f_clk / (64*CLK_DIV).
- After reset release:
  - First bclk rise is at clk edge CLK_DIV.
  - First falling event (first load event) is at edge 2*CLK_DIV.
- lrck, sdata and slot all update on the same clk edge as the bclk falling transition. They are stable for the whole following high phase, so the DAC samples them on the bclk rising edge.
- Latency from push into an empty FIFO to the MSB on sdata: data appears at the next load event. This is at most 64*CLK_DIV + 1 clk cycles.
- Sustained throughput: one pop per frame. The upstream sees in_ready drop once FIFO_DEPTH samples are pending.
- Reset asserted mid-frame: all outputs return to their reset values immediately and any buffered samples are discarded. Operation restarts at slot 0 with a fresh divider phase.

## Test plan
- Single sample, CLK_DIV=4: push 16'hA5C3 right after reset.
  - At edge 8: lrck=0, slot 1, sdata=1 (bit 15).
  - Slots 1..16 carry A5C3 MSB-first; lrck rises at slot 16; slots 17..31 carry bits 15..1 of A5C3.
  - Next slot 0 carries bit 0 = 1.
  - bclk period is 8 cycles.
- Underrun, no pushes: sdata stays 0, and underrun=1 from edge 2*CLK_DIV onward. A later push of 16'h7FFF then appears in the next frame, and underrun stays 1.
- Backpressure, FIFO_DEPTH=4: hold in_valid=1 with samples 1,2,3,4,5,6.
  - in_ready drops after 4 accepts; the fifth sample is accepted only after a load event.
  - Frames carry 1,2,3,4,5,6 in order, with no duplicates.
- Reset mid-frame: assert rst_n=0 during slot 20.
  - Immediately: bclk=lrck=sdata=underrun=0 and in_ready=0.
  - After release, the first load event is at 2*CLK_DIV with an empty FIFO, so zero is loaded and underrun=1.
- CLK_DIV=1, back-to-back pushes of 16'h8000 and 16'h0001:
  - bclk toggles every cycle and the frame is 64 cycles.
  - Frame 1 is 1000...0 on both channels; frame 2 ends with LSB 1 on each channel.
- Push coincident with load event on an empty FIFO: zero frame, underrun=1, and the pushed sample is sent in the following frame.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: mono-to-stereo I2S transmitter with a small sample FIFO.
// Samples arrive over valid/ready, are buffered, and each one is sent as a
// 32-slot I2S frame {S, S}. BCLK, LRCK and SDATA are all derived from clk.
module i2s_dac_tx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_sample,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata,
    output logic        underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic [AW:0] wptr_n, rptr_n, occ, occ_n;
    logic        fifo_empty, push, pop, fall, load;
    logic [15:0] load_word;

    logic [7:0]  div_cnt;
    logic [4:0]  slot;
    logic [4:0]  slot_n;
    logic [31:0] shreg;

    // FIFO bookkeeping and the frame-load decision
    always_comb begin
        occ        = wptr - rptr;
        fifo_empty = (occ == '0);
        fall       = (div_cnt == DIV_LAST) && bclk;
        load       = fall && (slot == '0);
        push       = in_valid && in_ready;
        pop        = load && !fifo_empty;
        wptr_n     = wptr + (AW + 1)'(push);
        rptr_n     = rptr + (AW + 1)'(pop);
        occ_n      = wptr_n - rptr_n;
        slot_n     = slot + 5'd1;
        load_word  = fifo_empty ? '0 : mem[rptr[AW-1:0]];
    end

    // Sample storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= in_sample;
        end
    end

    // FIFO pointers and registered ready, based on post-update occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            in_ready <= 1'b0;
        end else begin
            wptr     <= wptr_n;
            rptr     <= rptr_n;
            in_ready <= (occ_n != (AW + 1)'(FIFO_DEPTH));
        end
    end

    // Bit-clock divider, slot counter and frame serializer.
    // The shift register is loaded with F already shifted once, so each later
    // falling event emits F[32-s], and slot 0 naturally emits the previous F[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            bclk     <= 1'b0;
            slot     <= '0;
            lrck     <= 1'b0;
            sdata    <= 1'b0;
            shreg    <= '0;
            underrun <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (bclk) begin
                slot <= slot_n;
                lrck <= slot_n[4];
                if (load) begin
                    sdata <= load_word[15];
                    shreg <= {load_word[14:0], load_word, 1'b0};
                    if (fifo_empty) begin
                        underrun <= 1'b1;
                    end
                end else begin
                    sdata <= shreg[31];
                    shreg <= {shreg[30:0], 1'b0};
                end
            end
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: scoreboard bench for i2s_dac_tx. Two instances (CLK_DIV=4
// and CLK_DIV=1) share stimulus; the idle one is held in reset and a mux
// selects which one the frame monitor observes.
module tb_i2s_dac_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4_n, rst1_n, sel;
    logic [15:0] in_sample;
    logic        in_valid;

    logic ready4, bclk4, lrck4, sdata4, und4;
    logic ready1, bclk1, lrck1, sdata1, und1;

    i2s_dac_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .in_sample(in_sample), .in_valid(in_valid),
        .in_ready(ready4), .bclk(bclk4), .lrck(lrck4), .sdata(sdata4), .underrun(und4)
    );

    i2s_dac_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .in_sample(in_sample), .in_valid(in_valid),
        .in_ready(ready1), .bclk(bclk1), .lrck(lrck1), .sdata(sdata1), .underrun(und1)
    );

    logic m_rst_n, m_ready, m_bclk, m_lrck, m_sdata, m_und;
    assign m_rst_n = sel ? rst1_n : rst4_n;
    assign m_ready = sel ? ready1 : ready4;
    assign m_bclk  = sel ? bclk1  : bclk4;
    assign m_lrck  = sel ? lrck1  : lrck4;
    assign m_sdata = sel ? sdata1 : sdata4;
    assign m_und   = sel ? und1   : und4;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];

    // clk edges since reset release of the observed instance
    int cyc;
    always @(posedge clk or negedge m_rst_n) begin
        if (!m_rst_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples on each bclk rise, rebuilds frames and pops expectations
    initial begin : monitor
        int          mslot;
        int          nbits;
        logic [31:0] word;
        logic [31:0] full;
        mslot = 0;
        nbits = 0;
        word  = '0;
        forever begin
            @(posedge m_bclk or negedge m_rst_n);
            if (!m_rst_n) begin
                mslot = 0;
                nbits = 0;
            end else begin
                check("lrck_slot", 32'(m_lrck), 32'(mslot >= 16));
                if (mslot == 1) begin
                    word  = 32'(m_sdata);
                    nbits = 1;
                end else if (mslot != 0) begin
                    word  = {word[30:0], m_sdata};
                    nbits++;
                end else if (nbits == 31) begin
                    full  = {word[30:0], m_sdata};
                    nbits = 0;
                    if (exp_q.size() > 0) check("frame", full, exp_q.pop_front());
                end
                mslot = (mslot + 1) % 32;
            end
        end
    end

    task automatic do_reset(input logic use1);
        in_valid = 1'b0;
        rst4_n   = 1'b0;
        rst1_n   = 1'b0;
        @(negedge clk);
        sel = use1;
        @(negedge clk);
        check("rst_bclk",  32'(m_bclk),  32'd0);
        check("rst_lrck",  32'(m_lrck),  32'd0);
        check("rst_sdata", 32'(m_sdata), 32'd0);
        check("rst_und",   32'(m_und),   32'd0);
        check("rst_ready", 32'(m_ready), 32'd0);
        if (use1) rst1_n = 1'b1;
        else      rst4_n = 1'b1;
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Offer v (called at a negedge); acc returns the clk edge that accepted it
    task automatic push(input logic [15:0] v, output int acc);
        int g;
        g = 0;
        in_sample = v;
        in_valid  = 1'b1;
        while (!m_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (!m_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got in_ready=0, expected 1 within 2000 cycles");
        end
        @(negedge clk);
        acc = cyc;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 10000) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d frames pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // bclk period in clk cycles, measured between two rises
    task automatic bclk_period(output int per);
        int   first;
        logic prev;
        per   = 0;
        first = -1;
        prev  = m_bclk;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!prev && m_bclk) begin
                if (first < 0) first = i;
                else begin
                    per = i - first;
                    break;
                end
            end
            prev = m_bclk;
        end
    endtask

    initial begin : timeout
        #2ms;
        $display("FAIL global_timeout: got no finish, expected finish before 2ms");
        $fatal(1);
    end

    initial begin : stim
        int acc;
        int per;
        sel       = 1'b0;
        in_sample = '0;

        // single sample A5C3, then an underrun frame
        do_reset(1'b0);
        exp_q.push_back(32'hA5C3A5C3);
        exp_q.push_back(32'h0000_0000);
        push(16'hA5C3, acc);
        in_valid = 1'b0;
        check("t1_accept_edge", 32'(acc), 32'd2);
        wait_edge(4);
        check("t1_bclk_rise", 32'(m_bclk), 32'd1);
        check("t1_slot0_sdata", 32'(m_sdata), 32'd0);
        wait_edge(8);
        check("t1_e8_bclk", 32'(m_bclk), 32'd0);
        check("t1_e8_lrck", 32'(m_lrck), 32'd0);
        check("t1_e8_msb", 32'(m_sdata), 32'd1);
        check("t1_e8_und", 32'(m_und), 32'd0);
        bclk_period(per);
        check("t1_period", 32'(per), 32'd8);
        drain();
        check("t1_und_after", 32'(m_und), 32'd1);

        // underrun with no pushes, then 7FFF in the next frame
        do_reset(1'b0);
        exp_q.push_back(32'h0000_0000);
        wait_edge(7);
        check("t2_und_e7", 32'(m_und), 32'd0);
        wait_edge(8);
        check("t2_und_e8", 32'(m_und), 32'd1);
        check("t2_sdata_e8", 32'(m_sdata), 32'd0);
        exp_q.push_back(32'h7FFF7FFF);
        push(16'h7FFF, acc);
        in_valid = 1'b0;
        drain();
        check("t2_und_sticky", 32'(m_und), 32'd1);

        // backpressure: valid held with 1..6
        do_reset(1'b0);
        for (int i = 1; i <= 6; i++) exp_q.push_back({16'(i), 16'(i)});
        push(16'd1, acc);
        check("t3_acc1", 32'(acc), 32'd2);
        push(16'd2, acc);
        push(16'd3, acc);
        push(16'd4, acc);
        check("t3_acc4", 32'(acc), 32'd5);
        check("t3_full_ready", 32'(m_ready), 32'd0);
        push(16'd5, acc);
        check("t3_acc5", 32'(acc), 32'd9);
        push(16'd6, acc);
        check("t3_acc6", 32'(acc), 32'd265);
        in_valid = 1'b0;
        drain();
        check("t3_und", 32'(m_und), 32'd0);

        // reset in slot 20, buffered sample must be discarded
        do_reset(1'b0);
        push(16'h1234, acc);
        in_valid = 1'b0;
        wait_edge(164);
        check("t4_lrck_slot20", 32'(m_lrck), 32'd1);
        rst4_n = 1'b0;
        #1;
        check("t4_bclk", 32'(m_bclk), 32'd0);
        check("t4_lrck", 32'(m_lrck), 32'd0);
        check("t4_sdata", 32'(m_sdata), 32'd0);
        check("t4_ready", 32'(m_ready), 32'd0);
        do_reset(1'b0);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        wait_edge(1);
        check("t4_ready_e1", 32'(m_ready), 32'd1);
        wait_edge(7);
        check("t4_und_e7", 32'(m_und), 32'd0);
        wait_edge(8);
        check("t4_und_e8", 32'(m_und), 32'd1);
        drain();

        // CLK_DIV=1: 8000 coincides with the first load, 0001 follows
        do_reset(1'b1);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h8000_8000);
        exp_q.push_back(32'h0001_0001);
        push(16'h8000, acc);
        check("t5_acc1", 32'(acc), 32'd2);
        push(16'h0001, acc);
        check("t5_acc2", 32'(acc), 32'd3);
        in_valid = 1'b0;
        check("t5_und", 32'(m_und), 32'd1);
        bclk_period(per);
        check("t5_period", 32'(per), 32'd2);
        drain();

        // push coincident with the load event on an empty FIFO
        do_reset(1'b0);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h5A5A5A5A);
        wait_edge(7);
        push(16'h5A5A, acc);
        in_valid = 1'b0;
        check("t6_acc", 32'(acc), 32'd8);
        check("t6_und", 32'(m_und), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
